// File: rtl/flag_pkg.sv
// Shared types for the NZVC flag sequencing logic: flag bit indices, B.cond
// condition codes and the hazard controller state.
package flag_pkg;

  // Bit positions inside a 4-bit flags vector {C,V,Z,N}
  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_C = 3;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    HS = 4'd2,
    LO = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: condition code plus NZVC flags to taken.
// Also intended for any later conditional-select datapath.
module cond_eval
  import flag_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    taken = 1'b1;
    case (cond)
      EQ:      taken = z;
      NE:      taken = ~z;
      HS:      taken = c;
      LO:      taken = ~c;
      MI:      taken = n;
      PL:      taken = ~n;
      VS:      taken = v;
      VC:      taken = ~v;
      HI:      taken = c & ~z;
      LS:      taken = ~c | z;
      GE:      taken = (n == v);
      LT:      taken = (n != v);
      GT:      taken = ~z & (n == v);
      LE:      taken = z | (n != v);
      default: taken = 1'b1;  // AL and NV both execute unconditionally
    endcase
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// NZVC flag sequencer beside ID/EX: tracks in-flight flag setters, stalls B.cond
// until flags are written, resolves the branch. FLAG_HAZARD_FWD_EN enables forwarding.
module flag_hazard_ctrl
  import flag_pkg::*;
#(
  parameter int unsigned FLAG_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_bcond,
  input  logic             id_set_flags,
  input  logic [3:0]       id_cond,
  input  logic             ex_flush,
  input  logic [3:0]       ex_alu_flags,
  input  logic [3:0]       flags_q,
  output logic             flag_we,
  output logic             stall_id,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [FLAG_LAT-1:0] trk_q, trk_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pending;
  logic                hazard;
  logic                is_bcond;
  logic [3:0]          eval_flags;
  logic                taken;

`ifdef FLAG_HAZARD_FWD_EN
  // Every tracker stage except the one writing the register this cycle
  localparam logic [FLAG_LAT-1:0] OlderMask = ~(FLAG_LAT'(1) << (FLAG_LAT - 1));

  assign pending    = |(trk_q & OlderMask);
  assign eval_flags = trk_q[FLAG_LAT-1] ? ex_alu_flags : flags_q;
`else
  logic unused_alu_flags;

  // The flags register captures ex_alu_flags itself; only forwarding reads them here
  assign unused_alu_flags = ^ex_alu_flags;
  assign pending          = |trk_q;
  assign eval_flags       = flags_q;
`endif

  assign is_bcond = id_valid & id_is_bcond;
  assign hazard   = is_bcond & pending;

  cond_eval u_cond_eval (
    .cond  (cond_e'(id_cond)),
    .flags (eval_flags),
    .taken (taken)
  );

  assign flag_we   = trk_q[FLAG_LAT-1] & ~reset;
  assign stall_id  = hazard & ~reset;
  assign br_valid  = is_bcond & ~hazard & ~reset;
  assign br_taken  = taken & ~reset;
  assign stall_cnt = cnt_q;

  always_comb begin
    trk_d    = trk_q << 1;
    trk_d[0] = id_valid & id_set_flags & ~id_is_bcond & ~hazard & ~ex_flush;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN:     if (hazard) state_d = HOLD;
      HOLD:    if (!hazard) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_q   <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      trk_q   <= trk_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  a_hold_after_stall: assert property (@(posedge clk) disable iff (reset)
    stall_id |=> (state_q == HOLD));

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Bench for flag_hazard_ctrl: FLAG_LAT=1/CNT_W=4 and FLAG_LAT=3/CNT_W=16 instances
// on shared stimulus, checked against a write-calendar reference model.
module tb_flag_hazard_ctrl;
  import flag_pkg::*;

`ifdef FLAG_HAZARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif
  localparam int Lat [2]  = '{1, 3};
  localparam int CMax [2] = '{15, 65535};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_is_bcond, id_set_flags, ex_flush;
  logic [3:0] id_cond, ex_alu_flags;
  logic [3:0] fq1 = 4'h0, fq3 = 4'h0;
  logic       we1, st1, bv1, bt1, we3, st3, bv3, bt3;
  logic [3:0] cnt1;
  logic [15:0] cnt3;

  int checks = 0;
  int errors = 0;

  flag_hazard_ctrl #(.FLAG_LAT(1), .CNT_W(4)) u_l1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_bcond(id_is_bcond),
    .id_set_flags(id_set_flags), .id_cond(id_cond), .ex_flush(ex_flush),
    .ex_alu_flags(ex_alu_flags), .flags_q(fq1), .flag_we(we1), .stall_id(st1),
    .br_valid(bv1), .br_taken(bt1), .stall_cnt(cnt1)
  );

  flag_hazard_ctrl #(.FLAG_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_bcond(id_is_bcond),
    .id_set_flags(id_set_flags), .id_cond(id_cond), .ex_flush(ex_flush),
    .ex_alu_flags(ex_alu_flags), .flags_q(fq3), .flag_we(we3), .stall_id(st3),
    .br_valid(bv3), .br_taken(bt3), .stall_cnt(cnt3)
  );

  // Reference model: absolute cycle at which each accepted setter writes flags
  int         now = 0;
  bit         due [2][64];
  int         last_w [2] = '{-1, -1};
  logic [3:0] mfl [2] = '{4'h0, 4'h0};
  int         mcnt [2] = '{0, 0};
  bit         mprev [2] = '{0, 0};
  bit         e_we [2], e_st [2], e_bv [2], e_bt [2];
  bit         sv_we1, sv_we3;

  function automatic bit cond_ref(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, v, c, r;
    n = f[0]; z = f[1]; v = f[2]; c = f[3];
    case (cc[3:1])
      3'd0:    r = z;
      3'd1:    r = c;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = c && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return (cc[0] && cc != 4'hF) ? !r : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, now, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic we, input logic st, input logic bv,
                          input logic bt, input logic [31:0] cnt, input logic [31:0] stt);
    string p;
    p = (k == 0) ? "l1" : "l3";
    check({p, "_flag_we"}, we, e_we[k]);
    check({p, "_stall_id"}, st, e_st[k]);
    check({p, "_br_valid"}, bv, e_bv[k]);
    check({p, "_br_taken"}, bt, e_bt[k]);
    check({p, "_stall_cnt"}, cnt, mcnt[k]);
    check({p, "_state"}, stt, mprev[k] ? 32'(HOLD) : 32'(RUN));
  endtask

  task automatic evaluate();
    bit pend;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        last_w[k] = -1;
        for (int i = 0; i < 64; i++) due[k][i] = 1'b0;
        mcnt[k] = 0; mprev[k] = 1'b0;
        e_we[k] = 1'b0; e_st[k] = 1'b0; e_bv[k] = 1'b0; e_bt[k] = 1'b0;
      end else begin
        e_we[k] = due[k][now % 64];
        pend    = Fwd ? (last_w[k] > now) : (last_w[k] >= now);
        e_st[k] = id_valid && id_is_bcond && pend;
        e_bv[k] = id_valid && id_is_bcond && !e_st[k];
        e_bt[k] = cond_ref(id_cond, (Fwd && e_we[k]) ? ex_alu_flags : mfl[k]);
      end
    end
    cmp_inst(0, we1, st1, bv1, bt1, 32'(cnt1), 32'(u_l1.state_q));
    cmp_inst(1, we3, st3, bv3, bt3, 32'(cnt3), 32'(u_l3.state_q));
    sv_we1 = we1;
    sv_we3 = we3;
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    if (sv_we1) fq1 = ex_alu_flags;
    if (sv_we3) fq3 = ex_alu_flags;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (e_we[k]) mfl[k] = ex_alu_flags;
        due[k][now % 64] = 1'b0;
        if (e_st[k] && mcnt[k] < CMax[k]) mcnt[k]++;
        mprev[k] = e_st[k];
        if (id_valid && id_set_flags && !id_is_bcond && !e_st[k] && !ex_flush) begin
          w = now + Lat[k];
          due[k][w % 64] = 1'b1;
          last_w[k] = w;
        end
      end
    end
    now++;
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input bit b, input bit sf,
                       input logic [3:0] cc, input bit fl, input logic [3:0] alu);
    reset = r; id_valid = v; id_is_bcond = b; id_set_flags = sf;
    id_cond = cc; ex_flush = fl; ex_alu_flags = alu;
  endtask

  task automatic settle();
    @(negedge clk);
    evaluate();
  endtask

  task automatic setflags(input logic [3:0] f);
    fq1 = f; fq3 = f; mfl[0] = f; mfl[1] = f;
  endtask

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       taken;
  } tv_t;
  tv_t tv [19];

  initial begin
    // Flags are {C,V,Z,N}
    tv[0]  = '{4'd0,  4'b0010, 1'b1};  tv[1]  = '{4'd1,  4'b0010, 1'b0};
    tv[2]  = '{4'd2,  4'b1000, 1'b1};  tv[3]  = '{4'd3,  4'b1000, 1'b0};
    tv[4]  = '{4'd4,  4'b0001, 1'b1};  tv[5]  = '{4'd5,  4'b0001, 1'b0};
    tv[6]  = '{4'd6,  4'b0100, 1'b1};  tv[7]  = '{4'd7,  4'b0000, 1'b1};
    tv[8]  = '{4'd8,  4'b1000, 1'b1};  tv[9]  = '{4'd8,  4'b1010, 1'b0};
    tv[10] = '{4'd9,  4'b1010, 1'b1};  tv[11] = '{4'd10, 4'b0101, 1'b1};
    tv[12] = '{4'd11, 4'b0001, 1'b1};  tv[13] = '{4'd12, 4'b0000, 1'b1};
    tv[14] = '{4'd12, 4'b0010, 1'b0};  tv[15] = '{4'd13, 4'b0100, 1'b1};
    tv[16] = '{4'd14, 4'b0000, 1'b1};  tv[17] = '{4'd15, 4'b1111, 1'b1};
    tv[18] = '{4'd10, 4'b0001, 1'b0};

    // Reset state
    drive(1, 1, 1, 0, 4'd14, 0, 4'h0);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_br_taken", bt1, 1'b0);
      check("rst_cnt", cnt3, 16'd0);
      advance();
    end

    // Hand table of condition codes, tracker empty
    for (int i = 0; i < 19; i++) begin
      setflags(tv[i].flags);
      drive(0, 1, 1, 0, tv[i].cond, 0, ~tv[i].flags);
      settle();
      check("tbl_br_valid", bv1, 1'b1);
      check("tbl_br_taken_l1", bt1, tv[i].taken);
      check("tbl_br_taken_l3", bt3, tv[i].taken);
      advance();
    end

    // Full sweep of conditions over flag values
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        setflags(4'(f));
        drive(0, 1, 1, 0, 4'(c), 0, 4'(~f));
        settle();
        if (c >= 14) check("sweep_always", bt3, 1'b1);
        advance();
      end
    end

    // SUBS then B.EQ, ALU flags Z=1
    drive(0, 1, 0, 1, 4'd0, 0, 4'h0); settle(); advance();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, 1, 0, 4'd0, 0, 4'b0010);
      settle();
      if (c == 1) begin
`ifdef FLAG_HAZARD_FWD_EN
        check("a_fwd_nostall", st1, 1'b0);
        check("a_fwd_taken", bt1, 1'b1);
`else
        check("a_stall", st1, 1'b1);
        check("a_flag_we", we1, 1'b1);
`endif
      end
      if (c == 2) begin
        check("a_br_valid", bv1, 1'b1);
        check("a_br_taken", bt1, 1'b1);
`ifndef FLAG_HAZARD_FWD_EN
        check("a_stall_cnt", cnt1, 4'd1);
`endif
      end
      advance();
    end

    // ADDS, bubble, B.LT with N=1 V=0 on the FLAG_LAT=3 instance
    drive(0, 1, 0, 1, 4'd0, 0, 4'b0001); settle(); advance();
    drive(0, 0, 0, 0, 4'd0, 0, 4'b0001); settle(); advance();
    for (int c = 2; c <= 4; c++) begin
      drive(0, 1, 1, 0, 4'd11, 0, 4'b0001);
      settle();
      if (c == 2) check("b_stall_c2", st3, 1'b1);
      if (c == 3) begin
        check("b_state_hold", 32'(u_l3.state_q), 32'(HOLD));
`ifdef FLAG_HAZARD_FWD_EN
        check("b_fwd_nostall", st3, 1'b0);
        check("b_fwd_taken", bt3, 1'b1);
`else
        check("b_stall_c3", st3, 1'b1);
`endif
      end
      if (c == 4) begin
        check("b_br_valid", bv3, 1'b1);
        check("b_br_taken", bt3, 1'b1);
      end
      advance();
    end

    // Flushed ADDS never writes and never stalls a following B.NE
    setflags(4'h0);
    drive(0, 1, 0, 1, 4'd0, 1, 4'b0010); settle(); advance();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 1, 1, 0, 4'd1, 0, 4'b0010);
      settle();
      check("fl_stall", st3, 1'b0);
      check("fl_we", we3 | we1, 1'b0);
      check("fl_taken", bt3, 1'b1);
      advance();
    end

    // Reset asserted while the FLAG_LAT=3 instance is holding a B.cond
    drive(0, 1, 0, 1, 4'd0, 0, 4'h0); settle(); advance();
    for (int c = 1; c <= 4; c++) begin
      drive(c == 3, 1, 1, 0, 4'd0, 0, 4'h0);
      settle();
      if (c == 2) check("r_state_hold", 32'(u_l3.state_q), 32'(HOLD));
      if (c == 3) begin
        check("r_outs", {we3, st3, bv3, bt3}, 4'b0000);
        check("r_cnt", cnt3, 16'd0);
        check("r_state_run", 32'(u_l3.state_q), 32'(RUN));
      end
      if (c == 4) begin
        check("r_after_stall", st3, 1'b0);
        check("r_after_valid", bv3, 1'b1);
      end
      advance();
    end

    // Repeated 1-cycle stalls drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 1, 4'd0, 0, 4'(i)); settle(); advance();
      drive(0, 1, 1, 0, 4'd0, 0, 4'(i)); settle(); advance();
      drive(0, 1, 1, 0, 4'd0, 0, 4'(i)); settle(); advance();
    end
`ifndef FLAG_HAZARD_FWD_EN
    check("sat_cnt", cnt1, 4'hF);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 2) == 0,
            ($urandom % 2) == 0, 4'($urandom), ($urandom % 6) == 0, 4'($urandom));
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
